// File: rtl/uart_pkg.sv
// Shared UART constants and types for the receive path.
package uart_pkg;

  localparam int unsigned UART_DW    = 8;
  localparam int unsigned RX_FIFO_AW = 4;
  localparam int unsigned RX_FIFO_AF = 12;
  localparam int unsigned DROP_CNT_W = 8;

  typedef logic [UART_DW-1:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/consumer side and the receive FIFO.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int unsigned DW = UART_DW,
  parameter int unsigned AW = RX_FIFO_AW,
  parameter int unsigned CW = DROP_CNT_W
) ();

  logic [DW-1:0] rf_data;
  logic          fr_wrreq;
  logic          rdreq;
  logic          ovf_clr;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   usedw;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  modport master (
    output rf_data, fr_wrreq, rdreq, ovf_clr,
    input  q, q_valid, empty, full, almost_full, usedw, overflow, drop_cnt
  );

  modport slave (
    input  rf_data, fr_wrreq, rdreq, ovf_clr,
    output q, q_valid, empty, full, almost_full, usedw, overflow, drop_cnt
  );

endinterface

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage: register array, pointers, occupancy and flags.
// Callers must only assert i_rd_en when not empty and i_wr_en when not full
// (or together with a read).
module sync_fifo_core #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic [AW:0]   o_usedw,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_almost_full
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned UW    = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_usedw;
  logic [AW:0]   w_usedw_nxt;
  logic [DW-1:0] r_rd_data;
  logic          r_empty;
  logic          r_full;
  logic          r_almost_full;

  // Next occupancy; flags are registered from this so they track usedw exactly.
  always_comb begin
    w_usedw_nxt = r_usedw;
    if (i_wr_en && !i_rd_en) begin
      w_usedw_nxt = r_usedw + UW'(1);
    end else if (i_rd_en && !i_wr_en) begin
      w_usedw_nxt = r_usedw - UW'(1);
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, occupancy, flags and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_usedw       <= '0;
      r_rd_data     <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_usedw       <= w_usedw_nxt;
      r_empty       <= (w_usedw_nxt == '0);
      r_full        <= (w_usedw_nxt == UW'(DEPTH));
      r_almost_full <= (w_usedw_nxt >= UW'(AF_LEVEL));
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_usedw       = r_usedw;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver; drops and counts bytes on overflow.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int unsigned DW       = UART_DW,
  parameter int unsigned AW       = RX_FIFO_AW,
  parameter int unsigned AF_LEVEL = RX_FIFO_AF
) (
  input  logic           uart_clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  rx_bus
);

  logic                  w_rd_en;
  logic                  w_wr_en;
  logic                  w_ovf_evt;
  logic [DW-1:0]         w_q;
  logic [AW:0]           w_usedw;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_almost_full;
  logic                  r_q_valid;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Receiver cannot stall: a write into a full buffer only lands if a pop frees a slot.
  assign w_rd_en   = rx_bus.rdreq & ~w_empty;
  assign w_wr_en   = rx_bus.fr_wrreq & (~w_full | w_rd_en);
  assign w_ovf_evt = rx_bus.fr_wrreq & w_full & ~w_rd_en;

  sync_fifo_core #(
    .DW       (DW),
    .AW       (AW),
    .AF_LEVEL (AF_LEVEL)
  ) u_core (
    .clk           (uart_clk),
    .rst           (rst),
    .i_wr_en       (w_wr_en),
    .i_wr_data     (rx_bus.rf_data),
    .i_rd_en       (w_rd_en),
    .o_rd_data     (w_q),
    .o_usedw       (w_usedw),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_almost_full (w_almost_full)
  );

  // One-cycle strobe marking a freshly popped byte on q.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_rd_en;
    end
  end

  // Sticky overflow and saturating drop counter; a drop in the clear cycle wins.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
      if (rx_bus.ovf_clr) begin
        r_drop_cnt <= DROP_CNT_W'(1);
      end else if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end else if (rx_bus.ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign rx_bus.q           = w_q;
  assign rx_bus.q_valid     = r_q_valid;
  assign rx_bus.empty       = w_empty;
  assign rx_bus.full        = w_full;
  assign rx_bus.almost_full = w_almost_full;
  assign rx_bus.usedw       = w_usedw;
  assign rx_bus.overflow    = r_overflow;
  assign rx_bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: read-data scoreboard plus per-cycle flag checks.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic uart_clk = 1'b0;
  logic rst;

  always #5 uart_clk = ~uart_clk;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .uart_clk (uart_clk),
    .rst      (rst),
    .rx_bus   (bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  byte_t model[$];
  byte_t exp_q[$];
  bit    m_ovf;
  int    m_drop;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Monitor: every q_valid strobe must match the oldest expected byte.
  always @(posedge uart_clk) begin
    #1;
    if (rst === 1'b0 && bus.q_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_q_valid", 1, 0);
      end else begin
        byte_t e;
        e = exp_q.pop_front();
        check("q_data", int'(bus.q), int'(e));
      end
    end
  end

  task automatic check_state();
    check("usedw",       int'(bus.usedw),       model.size());
    check("empty",       int'(bus.empty),       int'(model.size() == 0));
    check("full",        int'(bus.full),        int'(model.size() == 16));
    check("almost_full", int'(bus.almost_full), int'(model.size() >= 12));
    check("overflow",    int'(bus.overflow),    int'(m_ovf));
    check("drop_cnt",    int'(bus.drop_cnt),    m_drop);
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic cyc(input bit wr, input byte_t d, input bit rd, input bit clr);
    int sz;
    bit rde, wre, ovf;
    sz  = model.size();
    rde = rd && (sz > 0);
    wre = wr && ((sz < 16) || rde);
    ovf = wr && (sz == 16) && !rde;
    bus.fr_wrreq = wr;
    bus.rf_data  = d;
    bus.rdreq    = rd;
    bus.ovf_clr  = clr;
    if (rde) exp_q.push_back(model.pop_front());
    if (wre) model.push_back(d);
    if (ovf) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge uart_clk);
    @(negedge uart_clk);
    bus.fr_wrreq = 1'b0;
    bus.rdreq    = 1'b0;
    bus.ovf_clr  = 1'b0;
    check("q_valid", int'(bus.q_valid), int'(rde));
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    bus.fr_wrreq = 1'b0;
    bus.rdreq    = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.rf_data  = '0;
    repeat (n) @(posedge uart_clk);
    @(negedge uart_clk);
    rst = 1'b0;
    model.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    check("rst_q",       int'(bus.q),       0);
    check("rst_q_valid", int'(bus.q_valid), 0);
    check("rst_usedw",   int'(bus.usedw),   0);
    check_state();
  endtask

  initial begin
    rst          = 1'b1;
    bus.fr_wrreq = 1'b0;
    bus.rdreq    = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.rf_data  = '0;
    @(negedge uart_clk);

    // Reset then idle; pops on empty are ignored
    do_reset(2);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    check("idle_q_hold", int'(bus.q), 0);

    // Basic ordering
    cyc(1, 8'h55, 0, 0); check("basic_usedw1", int'(bus.usedw), 1);
    cyc(1, 8'hAA, 0, 0); check("basic_usedw2", int'(bus.usedw), 2);
    cyc(1, 8'h0F, 0, 0); check("basic_usedw3", int'(bus.usedw), 3);
    cyc(0, 8'h00, 1, 0); check("basic_q55", int'(bus.q), 8'h55);
    cyc(0, 8'h00, 1, 0); check("basic_qAA", int'(bus.q), 8'hAA);
    cyc(0, 8'h00, 1, 0); check("basic_q0F", int'(bus.q), 8'h0F);
    check("basic_empty", int'(bus.empty), 1);

    // Fill, almost_full and full thresholds
    for (int i = 0; i < 16; i++) begin
      cyc(1, byte_t'(i), 0, 0);
      if (i == 10) check("af_below", int'(bus.almost_full), 0);
      if (i == 11) check("af_at12",  int'(bus.almost_full), 1);
      if (i == 14) check("full_15",  int'(bus.full),        0);
    end
    check("full_16", int'(bus.full), 1);

    // Overflow drops EE/EF
    cyc(1, 8'hEE, 0, 0);
    cyc(1, 8'hEF, 0, 0);
    check("ovf_flag",  int'(bus.overflow), 1);
    check("ovf_drop2", int'(bus.drop_cnt), 2);
    check("ovf_usedw", int'(bus.usedw),    16);

    // Drop counter saturation
    for (int i = 0; i < 254; i++) cyc(1, 8'hDD, 0, 0);
    check("drop_sat", int'(bus.drop_cnt), 255);
    cyc(0, 8'h00, 0, 1);
    check("clr_ovf",  int'(bus.overflow), 0);
    check("clr_drop", int'(bus.drop_cnt), 0);

    // Write with pop while full is accepted
    cyc(1, 8'h77, 1, 0);
    check("full_rw_usedw", int'(bus.usedw),    16);
    check("full_rw_ovf",   int'(bus.overflow), 0);
    check("full_rw_q",     int'(bus.q),        8'h00);

    // Overflow event beats a simultaneous clear
    cyc(1, 8'h88, 0, 1);
    check("prio_ovf",  int'(bus.overflow), 1);
    check("prio_drop", int'(bus.drop_cnt), 1);
    cyc(0, 8'h00, 0, 1);
    check("prio_clr_ovf",  int'(bus.overflow), 0);
    check("prio_clr_drop", int'(bus.drop_cnt), 0);

    // Drain: 01..0F then 77
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    check("drain_last", int'(bus.q),     8'h77);
    check("drain_empty", int'(bus.empty), 1);

    // Write with pop while empty: write only, no fall-through
    cyc(1, 8'h33, 1, 0);
    check("empty_rw_qv",    int'(bus.q_valid), 0);
    check("empty_rw_usedw", int'(bus.usedw),   1);
    cyc(0, 8'h00, 1, 0);
    check("empty_rw_q", int'(bus.q), 8'h33);

    // Interleaved traffic wrapping the pointers, ending at occupancy 5
    for (int i = 0; i < 40; i++) cyc(1, byte_t'(8'h40 + i), (i >= 5), 0);
    check("wrap_usedw", int'(bus.usedw), 5);

    // Reset mid-stream discards contents
    do_reset(1);
    check("midrst_empty", int'(bus.empty), 1);
    cyc(1, 8'hC3, 0, 0);
    cyc(0, 8'h00, 1, 0);
    check("midrst_q", int'(bus.q), 8'hC3);
    cyc(0, 8'h00, 0, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
